// File: rtl/xor_vector_checker.sv
// xor_vector_checker: exhaustive 3-input XOR truth-table checker (clk, rst_n, start -> a/b/c stimulus; d/a2/a3 responses -> busy, done, pass, err_count; first_fail/first_resp with MISMATCH_LOG_EN)
module xor_vector_checker #(
  parameter int HOLD_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       d,
  input  logic       a2,
  input  logic       a3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count
`ifdef MISMATCH_LOG_EN
  ,
  output logic [2:0] first_fail,
  output logic [2:0] first_resp
`endif
);
  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
  localparam logic [15:0] LAST = 16'(HOLD_CYCLES - 1);
  state_t      state_q;
  logic [2:0]  vec_q;
  logic [15:0] cnt_q;
  logic [3:0]  err_q, err_d;
  logic        busy_q, done_q, pass_q, last, mism;
`ifdef MISMATCH_LOG_EN
  logic [2:0]  ff_q, fr_q;
  assign first_fail = ff_q;
  assign first_resp = fr_q;
`endif
  assign {a, b, c} = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign last  = cnt_q == LAST;
  assign mism  = {d, a2, a3} != {^vec_q, vec_q[2] ^ vec_q[1], ^vec_q};
  assign err_d = err_q + 4'(last && mism);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifdef MISMATCH_LOG_EN
      ff_q    <= '0;
      fr_q    <= '0;
`endif
    end else
      case (state_q)
        IDLE:
          if (start) begin
            state_q <= HOLD;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef MISMATCH_LOG_EN
            ff_q    <= '0;
            fr_q    <= '0;
`endif
          end
        HOLD: begin
          cnt_q <= cnt_q + 16'd1;
          if (last) begin
            err_q <= err_d;
`ifdef MISMATCH_LOG_EN
            if (mism && err_q == 4'd0) begin
              ff_q <= vec_q;
              fr_q <= {d, a2, a3};
            end
`endif
            if (vec_q != 3'd7) begin
              vec_q <= vec_q + 3'd1;
              cnt_q <= '0;
            end else begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= err_d == 4'd0;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_xor_vector_checker.sv
// tb_xor_vector_checker: table-driven and randomized checks of xor_vector_checker against a gate model with injectable faults
module tb_xor_vector_checker;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
  int checks = 0, errors = 0, mode = 0;
  logic [2:0] mask [8];
  always #5 clk = ~clk;
  function automatic logic [2:0] gate(int m, logic [2:0] v);
    logic [2:0] t;
    t = {^v, v[2] ^ v[1], ^v};
    if (m == 1) t[2] = 1'b0;
    if (m == 2) t[1] = ~t[1];
    if (m == 3) t = t ^ mask[v];
    return t;
  endfunction
  logic a4, b4, c4, busy4, done4, pass4, a_2, b_2, c_2, busy2, done2, pass2;
  logic [3:0] err4, err2;
  logic [2:0] r4, r2;
  assign r4 = gate(mode, {a4, b4, c4});
  assign r2 = gate(mode, {a_2, b_2, c_2});
`ifdef MISMATCH_LOG_EN
  logic [2:0] ff4, fr4, ff2, fr2;
`endif
  xor_vector_checker #(.HOLD_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .a(a4), .b(b4), .c(c4),
    .d(r4[2]), .a2(r4[1]), .a3(r4[0]), .busy(busy4), .done(done4), .pass(pass4), .err_count(err4)
`ifdef MISMATCH_LOG_EN
    , .first_fail(ff4), .first_resp(fr4)
`endif
  );
  xor_vector_checker #(.HOLD_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .a(a_2), .b(b_2), .c(c_2),
    .d(r2[2]), .a2(r2[1]), .a3(r2[0]), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef MISMATCH_LOG_EN
    , .first_fail(ff2), .first_resp(fr2)
`endif
  );
  logic [2:0] abc;
  logic       busy, done, pass;
  logic [3:0] err;
  assign abc  = sel ? {a_2, b_2, c_2} : {a4, b4, c4};
  assign busy = sel ? busy2 : busy4;
  assign done = sel ? done2 : done4;
  assign pass = sel ? pass2 : pass4;
  assign err  = sel ? err2 : err4;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic ref_model(output int e, output int ff, output logic [2:0] fr);
    e = 0; ff = 0; fr = '0;
    for (int v = 0; v < 8; v++) begin
      logic [2:0] want, got;
      want = {^3'(v), 3'(v) >> 2 != ((3'(v) >> 1) & 3'd1), ^3'(v)};
      got  = gate(mode, 3'(v));
      if (got != want) begin
        if (e == 0) begin ff = v; fr = got; end
        e++;
      end
    end
  endtask
  task automatic run(int h, bit hold_start, bit pulse_mid, int exp_err, bit exp_pass);
    int e, ff;
    logic [2:0] fr;
    bit ok = 1'b1;
    ref_model(e, ff, fr);
    chk("ref_err", 32'(e), 32'(exp_err));
    sel = (h == 2);
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    for (int j = 0; j < 8 * h; j++) begin
      if (j > 0) @(negedge clk);
      if (pulse_mid && j == 10) start = 1'b1;
      if (pulse_mid && j == 12) start = 1'b0;
      if ({abc, busy, done} !== {3'(j / h), 1'b1, 1'b0}) ok = 1'b0;
    end
    chk("trace", 32'(ok), 32'd1);
    @(negedge clk);
    chk("done_pulse", {30'd0, done, busy}, 32'd2);
    chk("err_count", 32'(err), 32'(exp_err));
    chk("pass", 32'(pass), 32'(exp_pass));
`ifdef MISMATCH_LOG_EN
    if (e > 0) begin
      chk("first_fail", 32'(sel ? ff2 : ff4), 32'(ff));
      chk("first_resp", 32'(sel ? fr2 : fr4), 32'(fr));
    end
`endif
    @(negedge clk);
    chk("done_fall", {30'd0, done, busy}, 32'd0);
    if (hold_start) begin
      @(negedge clk);
      chk("restart", {30'd0, busy, 1'b0}, 32'd2);
      start = 1'b0;
      repeat (8 * h + 2) @(negedge clk);
      chk("restart_idle", 32'(busy), 32'd0);
    end
  endtask
  typedef struct {int mode; int h; bit hs; bit pm; int err; bit pass;} row_t;
  row_t tbl [7];
  initial begin
    bit ok;
    int e, ff;
    logic [2:0] fr;
    tbl = '{'{0, 4, 0, 0, 0, 1}, '{1, 4, 0, 0, 4, 0}, '{2, 4, 0, 0, 8, 0},
            '{0, 2, 0, 0, 0, 1}, '{1, 2, 0, 0, 4, 0}, '{0, 4, 1, 0, 0, 1},
            '{0, 4, 0, 1, 0, 1}};
    repeat (3) @(negedge clk);
    chk("reset4", {23'd0, a4, b4, c4, busy4, done4, pass4, err4}, 32'd0);
    chk("reset2", {23'd0, a_2, b_2, c_2, busy2, done2, pass2, err2}, 32'd0);
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      mode = tbl[i].mode;
      run(tbl[i].h, tbl[i].hs, tbl[i].pm, tbl[i].err, tbl[i].pass);
    end
    mode = 1; sel = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(negedge clk);
    chk("pre_reset_err", 32'(err4), 32'd2);
    chk("pre_reset_vec", 32'({a4, b4, c4}), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset", {23'd0, a4, b4, c4, busy4, done4, pass4, err4}, 32'd0);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done4 || busy4) ok = 1'b0;
    end
    chk("no_done_after_reset", 32'(ok), 32'd1);
    mode = 0;
    run(4, 0, 0, 0, 1);
    for (int r = 0; r < 8; r++) begin
      mode = 3;
      foreach (mask[v]) mask[v] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      ref_model(e, ff, fr);
      run(($urandom_range(0, 1) == 1) ? 2 : 4, 0, 0, e, e == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
